// File: rtl/temp_spi_pkg.sv
// ---------------------------------------------------------------------------
// temp_spi_pkg
// Shared types and constants for the temperature-sensor SPI poll controller.
//   state_e          : frame sequencer states (IDLE -> SETUP -> SHIFT -> HOLD)
//   CMD_BYTE_DEFAULT : "read temperature register" command byte
//   RX_BYTES_MAX     : largest supported number of data bytes per frame
//   HALF_PER_BYTE    : SCLK half-periods spent on one byte (8 bits x 2)
// ---------------------------------------------------------------------------
package temp_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  localparam logic [7:0] CMD_BYTE_DEFAULT = 8'h50;
  localparam int         RX_BYTES_MAX     = 4;
  localparam int         HALF_PER_BYTE    = 16;

endpackage

// File: rtl/sclk_tick_gen.sv
// ---------------------------------------------------------------------------
// sclk_tick_gen
// Free-running CLK_DIV divider producing one SCLK half-period tick.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   clr   : holds the counter at zero (no ticks while asserted)
//   tick  : high for one clk cycle every CLK_DIV cycles while clr is low
// ---------------------------------------------------------------------------
module sclk_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // next count: wrap at CLK_DIV-1, forced to zero by clr
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = !clr && (cnt_q == CNT_LAST);

endmodule

// File: rtl/temp_spi_poll_ctrl.sv
// ---------------------------------------------------------------------------
// temp_spi_poll_ctrl
// Sequences a byte-level SPI shifter to read a temperature sensor: one command
// byte out, RX_BYTES data bytes in, per frame. Frames start from a poll timer
// or a host trigger; requests arriving while busy are queued (depth one).
//
// Optional build macro TEMP_SPI_AVG_EN: temp becomes the moving average of the
// last four results instead of the raw last result.
//
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   enable      : 1 = poll timer runs, 0 = timer held at zero
//   trig        : one-cycle request for an immediate frame
//   spi_rx      : byte received by the shifter
//   spi_sclk    : SPI clock, mode 0 (idle low)
//   spi_cs_n    : chip select, active low
//   spi_load    : shifter load strobe for spi_tx
//   spi_tx      : byte to load into the shifter
//   busy        : frame in progress (cs_n low)
//   temp        : last result, first received byte in the MSBs
//   temp_valid  : one-cycle pulse when temp updates
// ---------------------------------------------------------------------------
module temp_spi_poll_ctrl
  import temp_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned POLL_PERIOD = 1000000,
  parameter logic [7:0]  CMD_BYTE    = CMD_BYTE_DEFAULT,
  parameter int unsigned RX_BYTES    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  trig,
  input  logic [7:0]            spi_rx,
  output logic                  spi_sclk,
  output logic                  spi_cs_n,
  output logic                  spi_load,
  output logic [7:0]            spi_tx,
  output logic                  busy,
  output logic [8*RX_BYTES-1:0] temp,
  output logic                  temp_valid
);

  localparam int TW = 8 * RX_BYTES;
  localparam int PW = $clog2(POLL_PERIOD);
  localparam int GW = $clog2(2 * CLK_DIV);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(2 * CLK_DIV - 1);
  localparam logic [2:0]    LAST_BYTE = 3'(RX_BYTES);

  state_e          state_q, state_d;
  logic [6:0]      hc_q, hc_d;          // half-period counter within a state
  logic [PW-1:0]   poll_cnt_q, poll_cnt_d;
  logic            pending_q, pending_d;
  logic [GW-1:0]   gap_q, gap_d;        // cycles cs_n has been high, saturating
  logic            sclk_q, sclk_d;
  logic            cs_n_q, cs_n_d;
  logic            load_q, load_d;
  logic [7:0]      tx_q, tx_d;
  logic            busy_q, busy_d;
  logic [TW-1:0]   shadow_q, shadow_d;
  logic [TW-1:0]   temp_q, temp_d;
  logic            temp_valid_q, temp_valid_d;

  logic            tick_s;
  logic            poll_tick_s;
  logic            start_s;
  logic            done_s;
  logic [2:0]      byte_idx_s;
  logic [3:0]      ph_s;
  logic [TW-1:0]   result_s;

  sclk_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == ST_IDLE),
    .tick  (tick_s)
  );

  // In SHIFT, hc counts half-periods: upper bits select the byte, lower
  // nibble the phase (even = sclk high, odd = sclk low).
  assign byte_idx_s  = hc_q[6:4];
  assign ph_s        = hc_q[3:0];
  assign poll_tick_s = enable && (poll_cnt_q == POLL_LAST);
  // A new frame may only start once cs_n has been high for 2*CLK_DIV cycles.
  assign start_s     = (state_q == ST_IDLE) && (gap_q == GAP_LAST) &&
                       (trig || poll_tick_s || pending_q);
  assign done_s      = (state_q == ST_HOLD) && tick_s && (hc_q == 7'd1);

`ifdef TEMP_SPI_AVG_EN
  logic [TW-1:0] hist_q [4];
  logic [TW-1:0] hist_d [4];
  logic [TW+1:0] sum_q, sum_d;

  // running sum of the four newest results; oldest entry drops out
  always_comb begin
    hist_d = hist_q;
    sum_d  = sum_q;
    if (done_s) begin
      sum_d     = sum_q + {2'b00, shadow_q} - {2'b00, hist_q[3]};
      hist_d[0] = shadow_q;
      hist_d[1] = hist_q[0];
      hist_d[2] = hist_q[1];
      hist_d[3] = hist_q[2];
    end else begin
      sum_d = sum_q;
    end
  end

  // history and sum registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        hist_q[i] <= '0;
      end
      sum_q <= '0;
    end else begin
      hist_q <= hist_d;
      sum_q  <= sum_d;
    end
  end

  assign result_s = sum_d[TW+1:2];
`else
  assign result_s = shadow_q;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) state_d = ST_SETUP;
        else         state_d = ST_IDLE;
      end
      ST_SETUP: begin
        if (tick_s && (hc_q == 7'd1)) state_d = ST_SHIFT;
        else                          state_d = ST_SETUP;
      end
      ST_SHIFT: begin
        if (tick_s && (ph_s == 4'd15) && (byte_idx_s == LAST_BYTE)) state_d = ST_HOLD;
        else                                                        state_d = ST_SHIFT;
      end
      ST_HOLD: begin
        if (done_s) state_d = ST_IDLE;
        else        state_d = ST_HOLD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // output / datapath next values
  always_comb begin
    hc_d         = hc_q;
    poll_cnt_d   = poll_cnt_q;
    pending_d    = pending_q;
    gap_d        = gap_q;
    sclk_d       = sclk_q;
    cs_n_d       = cs_n_q;
    load_d       = load_q;
    tx_d         = tx_q;
    busy_d       = busy_q;
    shadow_d     = shadow_q;
    temp_d       = temp_q;
    temp_valid_d = 1'b0;

    if (!enable)          poll_cnt_d = '0;
    else if (poll_tick_s) poll_cnt_d = '0;
    else                  poll_cnt_d = poll_cnt_q + PW'(1);

    // one queued request at most; the frame that starts consumes all requests
    if (start_s)                   pending_d = 1'b0;
    else if (trig || poll_tick_s)  pending_d = 1'b1;
    else                           pending_d = pending_q;

    if ((state_q == ST_IDLE) && (gap_q != GAP_LAST)) gap_d = gap_q + GW'(1);
    else                                             gap_d = gap_q;

    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          cs_n_d = 1'b0;
          busy_d = 1'b1;
          load_d = 1'b1;
          tx_d   = CMD_BYTE;
          hc_d   = 7'd0;
          sclk_d = 1'b0;
        end else begin
          hc_d = hc_q;
        end
      end
      ST_SETUP: begin
        if (tick_s && (hc_q == 7'd1)) begin
          hc_d   = 7'd0;
          sclk_d = 1'b1;       // first rise of the command byte
          load_d = 1'b0;
        end else if (tick_s) begin
          hc_d = hc_q + 7'd1;
        end else begin
          hc_d = hc_q;
        end
      end
      ST_SHIFT: begin
        if (tick_s && (ph_s == 4'd15) && (byte_idx_s == LAST_BYTE)) begin
          hc_d   = 7'd0;
          sclk_d = 1'b0;
          load_d = 1'b0;
        end else if (tick_s) begin
          hc_d   = hc_q + 7'd1;
          sclk_d = !sclk_q;
          // 8th fall of a byte: load the next byte during the following low phase
          if ((ph_s == 4'd14) && (byte_idx_s < LAST_BYTE)) begin
            load_d = 1'b1;
            tx_d   = 8'h00;
          end else if (ph_s == 4'd15) begin
            load_d = 1'b0;
          end else begin
            load_d = load_q;
          end
          // capture the data byte that has just completed
          if (ph_s == 4'd14) begin
            for (int k = 0; k < int'(RX_BYTES); k++) begin
              if (byte_idx_s == 3'(k + 1)) shadow_d[TW-8-8*k +: 8] = spi_rx;
            end
          end else begin
            shadow_d = shadow_q;
          end
        end else begin
          hc_d = hc_q;
        end
      end
      ST_HOLD: begin
        if (done_s) begin
          hc_d         = 7'd0;
          cs_n_d       = 1'b1;
          busy_d       = 1'b0;
          gap_d        = '0;
          temp_d       = result_s;
          temp_valid_d = 1'b1;
        end else if (tick_s) begin
          hc_d = hc_q + 7'd1;
        end else begin
          hc_d = hc_q;
        end
      end
      default: begin
        hc_d = 7'd0;
      end
    endcase
  end

  // datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_q         <= 7'd0;
      poll_cnt_q   <= '0;
      pending_q    <= 1'b0;
      gap_q        <= GAP_LAST;
      sclk_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      load_q       <= 1'b0;
      tx_q         <= 8'h00;
      busy_q       <= 1'b0;
      shadow_q     <= '0;
      temp_q       <= '0;
      temp_valid_q <= 1'b0;
    end else begin
      hc_q         <= hc_d;
      poll_cnt_q   <= poll_cnt_d;
      pending_q    <= pending_d;
      gap_q        <= gap_d;
      sclk_q       <= sclk_d;
      cs_n_q       <= cs_n_d;
      load_q       <= load_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      shadow_q     <= shadow_d;
      temp_q       <= temp_d;
      temp_valid_q <= temp_valid_d;
    end
  end

  assign spi_sclk   = sclk_q;
  assign spi_cs_n   = cs_n_q;
  assign spi_load   = load_q;
  assign spi_tx     = tx_q;
  assign busy       = busy_q;
  assign temp       = temp_q;
  assign temp_valid = temp_valid_q;

endmodule
